free_list: RTL

//   Circular free list of physical register tags for the rename stage. Hands one free preg per

---
 rtl/free_list_if.sv | 32 +++
 rtl/free_list.sv | 82 ++++++++
 2 files changed

// File: rtl/free_list_if.sv
// Rename-stage free list port bundle: dispatch alloc, commit release, flush, status.
interface free_list_if #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32
);
    localparam int DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              flush;
    logic              alloc_req;
    logic              alloc_valid;
    logic [PREG_W-1:0] alloc_preg;
    logic              commit_valid;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic              free_list_empty;
    logic              free_list_full;
    logic [CNT_W-1:0]  free_count;

    modport master (
        output flush, alloc_req, commit_valid, free_valid, free_preg,
        input  alloc_valid, alloc_preg, free_list_empty, free_list_full,
        input  free_count
    );

    modport slave (
        input  flush, alloc_req, commit_valid, free_valid, free_preg,
        output alloc_valid, alloc_preg, free_list_empty, free_list_full,
        output free_count
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags with speculative
// allocation rollback on flush.
module free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32
) (
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave bus
);
    localparam int DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int PREG_W = $clog2(NUM_PREGS);
    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W  = PTR_W - 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [PREG_W-1:0] r_entries [DEPTH];
    logic [PTR_W-1:0]  r_spec_head;
    logic [PTR_W-1:0]  r_commit_head;
    logic [PTR_W-1:0]  r_tail;

    logic [PTR_W-1:0]  w_diff;
    logic [PTR_W-1:0]  w_commit_nxt;
    logic              w_empty;
    logic              w_full;
    logic              w_grant;
    logic              w_push;

    assign w_diff  = r_tail - r_spec_head;
    assign w_empty = (r_spec_head == r_tail);
    assign w_full  = (r_spec_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
                     (r_spec_head[PTR_W-1] != r_tail[PTR_W-1]);
    assign w_grant = bus.alloc_req && !w_empty && !bus.flush;
    assign w_push  = bus.free_valid && !w_full;

    assign w_commit_nxt = r_commit_head + PTR_W'(bus.commit_valid);

    assign bus.alloc_valid     = !w_empty;
    assign bus.alloc_preg      = r_entries[r_spec_head[IDX_W-1:0]];
    assign bus.free_list_empty = w_empty;
    assign bus.free_list_full  = w_full;
    assign bus.free_count      = CNT_W'(w_diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= PREG_W'(NUM_AREGS + i);
            end
        end else if (w_push) begin
            r_entries[r_tail[IDX_W-1:0]] <= bus.free_preg;
        end
    end

    // Flush rewinds spec_head only; rolled-back tags are still in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= PTR_W'(DEPTH);
        end else begin
            r_commit_head <= w_commit_nxt;
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (bus.flush) begin
                r_spec_head <= w_commit_nxt;
            end else if (w_grant) begin
                r_spec_head <= r_spec_head + PTR_W'(1);
            end
        end
    end

    a_no_free_when_full: assert property (
        @(posedge clk) disable iff (rst)
        !(bus.free_valid && w_full)
    );

    a_commit_behind_spec: assert property (
        @(posedge clk) disable iff (rst)
        !(bus.commit_valid && (r_commit_head == r_spec_head))
    );
endmodule
